// File: rtl/sha256_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sha256_pkg : shared widths, word counts and reader state encoding
// Revision   : 1.0
// ---------------------------------------------------------------------------
package sha256_pkg;

  localparam int WORD_W       = 32;
  localparam int DIGEST_W     = 256;
  localparam int SHA256_WORDS = 8;
  localparam int SHA224_WORDS = 7;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_SEND = 1'b1
  } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/sha256_digest_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sha256_digest_reader : snapshots H0..H7 on capture and streams them out as
//                        32-bit words over valid/ready. SHA256_DIGEST_SHA224_EN
//                        limits the stream to H0..H6 (SHA-224).
// Revision             : 1.0
// ---------------------------------------------------------------------------
module sha256_digest_reader
  import sha256_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                capture,
  input  logic [DIGEST_W-1:0] digest_i,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_W-1:0]   out_data,
  output logic                out_last,
  output logic                busy,
  output logic                done
);

`ifdef SHA256_DIGEST_SHA224_EN
  localparam logic [2:0] LAST = 3'(SHA224_WORDS - 1);
`else
  localparam logic [2:0] LAST = 3'(NUM_WORDS - 1);
`endif

  rd_state_t           state_q, state_d;
  logic [DIGEST_W-1:0] buf_q, buf_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                done_q, done_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RD_IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (capture) begin
          buf_d   = digest_i;
          cnt_d   = '0;
          state_d = RD_SEND;
        end
      end
      RD_SEND: begin
        // capture is deliberately not looked at here: no queueing while busy
        if (out_ready) begin
          if (cnt_q == LAST) begin
            state_d = RD_IDLE;
            buf_d   = '0;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            buf_d = {buf_q[DIGEST_W-WORD_W-1:0], {WORD_W{1'b0}}};
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  // All outputs decode registered state only, so out_ready never reaches them.
  assign out_valid = (state_q == RD_SEND);
  assign busy      = (state_q == RD_SEND);
  assign out_data  = out_valid ? buf_q[DIGEST_W-1 -: WORD_W] : '0;
  assign out_last  = out_valid && (cnt_q == LAST);
  assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sha256_digest_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sha256_digest_reader : queue-based reference model plus directed and
//                           randomized stimulus for sha256_digest_reader.
// Revision                : 1.0
// ---------------------------------------------------------------------------
module tb_sha256_digest_reader;

`ifdef SHA256_DIGEST_SHA224_EN
  localparam int NW = 7;
  localparam logic [255:0] REF_D = {32'hd14a028c, 32'h2a3a2bc9, 32'h476102bb, 32'h288234c4,
                                    32'h15a2b01f, 32'h828ea62a, 32'hc5b3e42f, 32'hdeadbeef};
  logic [31:0] ref_w [0:7] = '{32'hd14a028c, 32'h2a3a2bc9, 32'h476102bb, 32'h288234c4,
                               32'h15a2b01f, 32'h828ea62a, 32'hc5b3e42f, 32'h00000000};
`else
  localparam int NW = 8;
  localparam logic [255:0] REF_D = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
  logic [31:0] ref_w [0:7] = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                               32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
`endif
  localparam logic [255:0] SEQ_D = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         capture = 1'b0;
  logic [255:0] digest_i = '0;
  logic         out_ready = 1'b0;
  logic         out_valid, out_last, busy, done;
  logic [31:0]  out_data;

  sha256_digest_reader dut (
    .CLK(CLK), .RST(RST), .capture(capture), .digest_i(digest_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Reference model: the words still owed to the consumer, in order.
  logic [31:0] expq[$];
  logic        done_exp = 1'b0;
  logic        armed = 1'b0;
  logic [31:0] ew;
  logic [31:0] got[$];
  int acc_count = 0, cap_c = 0, done_c = 0, done_count = 0, hs_count = 0;
  int first_word_c = -1, bad_word_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge CLK) begin
    if (armed) begin
      ew = (expq.size() != 0) ? expq[0] : 32'h0;
      chk("out_valid", {31'b0, out_valid}, {31'b0, expq.size() != 0});
      chk("busy", {31'b0, busy}, {31'b0, expq.size() != 0});
      chk("out_data", out_data, ew);
      chk("out_last", {31'b0, out_last}, {31'b0, expq.size() == 1});
      chk("done", {31'b0, done}, {31'b0, done_exp});
      if (done) begin done_c = cyc; done_count++; end
      if (out_valid && first_word_c < 0) first_word_c = cyc;
      if (out_valid && out_data == 32'hdeadbeef) bad_word_seen++;
    end
    if (RST) begin
      expq.delete();
      done_exp = 1'b0;
      if (cyc >= 1) armed = 1'b1;
    end else begin
      done_exp = 1'b0;
      if (expq.size() != 0) begin
        if (out_ready) begin
          got.push_back(out_data);
          hs_count++;
          void'(expq.pop_front());
          if (expq.size() == 0) done_exp = 1'b1;
        end
      end else if (capture) begin
        for (int i = 0; i < NW; i++) expq.push_back(digest_i[255 - 32*i -: 32]);
        acc_count++;
        cap_c = cyc;
        first_word_c = -1;
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic rand_digest();
    for (int j = 0; j < 8; j++) digest_i[32*j +: 32] = $urandom();
  endtask

  task automatic cap(input logic [255:0] d);
    capture  = 1'b1;
    digest_i = d;
    step();
    capture = 1'b0;
    rand_digest();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (expq.size() != 0 || done_exp) begin
      step();
      n++;
      if (n > budget) begin
        checks++;
        failures++;
        $display("FAIL wait_idle: actual=timeout required=idle within %0d cycles", budget);
        break;
      end
    end
    step();
  endtask

  task automatic chk_ref_words(input string name);
    chk({name, "_count"}, got.size(), NW);
    for (int i = 0; i < NW && i < got.size(); i++) chk(name, got[i], ref_w[i]);
  endtask

  initial begin
    int hs0, acc0, cap1, dn0;
    logic [2:0] pat;

    repeat (3) step();
    RST = 1'b0;
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);

    // basic stream
    out_ready = 1'b1;
    got.delete();
    cap(REF_D);
    wait_idle(50);
    chk_ref_words("basic_word");
    chk("first_word_latency", first_word_c - cap_c, 1);
    chk("done_latency", done_c - cap_c, NW + 1);
    chk("h7_never_output", bad_word_seen, 0);

    // backpressure 1,0,0,...
    got.delete();
    hs0 = hs_count;
    pat = 3'b001;
    cap(REF_D);
    for (int k = 0; k < 100 && (expq.size() != 0 || done_exp); k++) begin
      out_ready = pat[k % 3];
      step();
    end
    out_ready = 1'b1;
    wait_idle(50);
    chk("bp_handshakes", hs_count - hs0, NW);
    chk_ref_words("bp_word");

    // capture while busy: during word 3 and on the final handshake cycle
    got.delete();
    acc0 = acc_count;
    cap(REF_D);
    repeat (3) step();
    capture = 1'b1; digest_i = '1;
    step();
    capture = 1'b0;
    repeat (NW - 5) step();
    capture = 1'b1; digest_i = '1;
    step();
    capture = 1'b0;
    wait_idle(50);
    repeat (3) step();
    chk("busy_capture_accepts", acc_count - acc0, 1);
    chk_ref_words("busy_word");

    // reset mid-stream
    dn0 = done_count;
    cap(REF_D);
    repeat (4) step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_out_data", out_data, 32'd0);
    chk("abort_out_last", {31'b0, out_last}, 32'd0);
    repeat (3) step();
    chk("abort_no_done", done_count - dn0, 0);
    got.delete();
    cap(REF_D);
    chk("after_abort_h0", out_data, ref_w[0]);
    wait_idle(50);

    // back-to-back captures
    got.delete();
    acc0 = acc_count;
    capture = 1'b1;
    digest_i = REF_D;
    step();
    cap1 = cap_c;
    digest_i = SEQ_D;
    for (int k = 0; k < 30 && acc_count == acc0 + 1; k++) step();
    capture = 1'b0;
    chk("b2b_capture_gap", cap_c - cap1, NW + 1);
    wait_idle(50);
    chk("b2b_words", got.size(), 2 * NW);
    chk("b2b_second_done", done_c - cap1, 2 * NW + 2);
    if (got.size() == 2 * NW) begin
      chk("b2b_first_of_second", got[NW], 32'd1);
      chk("b2b_last_of_second", got[2*NW-1], NW);
    end

    // randomized traffic
    for (int k = 0; k < 800; k++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      capture   = ($urandom_range(0, 3) == 0);
      RST       = ($urandom_range(0, 99) == 0);
      rand_digest();
      step();
    end
    RST = 1'b0;
    capture = 1'b0;
    out_ready = 1'b1;
    wait_idle(50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
